// File: rtl/hdmits_pkg.sv
// Shared constants and helpers for the HDMI-over-Ethernet TX/RX packet path.
// Offsets are byte positions counted from the first preamble byte on GMII.
package hdmits_pkg;

  localparam logic [10:0] OFS_ETYPE = 11'h014;
  localparam logic [10:0] OFS_INFO  = 11'h032;
  localparam logic [10:0] OFS_PAY   = 11'h035;

  localparam logic [7:0]  PKT_VIDEO = 8'h00;
  localparam logic [7:0]  PKT_AUDIO = 8'h01;

  localparam logic [15:0] ETH_IPV4  = 16'h0800;
  localparam logic [7:0]  IP_VER    = 8'h45;
  localparam logic [7:0]  IP_UDP    = 8'h11;
  localparam logic [7:0]  IP_TTL    = 8'h40;
  localparam logic [15:0] IP_FLAGS  = 16'h4000;

  localparam int IFG_LEN = 12;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_HDR, ST_INFO, ST_PAY, ST_FCS, ST_IFG
  } tx_state_e;

  // Header checksum; id, TOS and checksum words are zero and drop out of the sum.
  function automatic logic [15:0] ip_csum(input logic [15:0] tot_len,
                                          input logic [31:0] src,
                                          input logic [31:0] dst);
    logic [31:0] s;
    s = {16'h0, IP_VER, 8'h00} + {16'h0, tot_len} + {16'h0, IP_FLAGS}
      + {16'h0, IP_TTL, IP_UDP}
      + {16'h0, src[31:16]} + {16'h0, src[15:0]}
      + {16'h0, dst[31:16]} + {16'h0, dst[15:0]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected Ethernet CRC-32; exposes the raw running value so the
// caller applies the final complement (the RX checker compares it directly).
module crc32_d8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_q;

  function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || init) crc_q <= '1;
    else if (en)     crc_q <= crc_next(crc_q, d);
  end

  assign crc = crc_q;

endmodule

// File: rtl/fifo2gmii24.sv
// GMII UDP/IPv4 video packetizer: drains pixel-pair words from an FWFT FIFO
// and emits one fixed-length frame per payload_words words.
module fifo2gmii24
  import hdmits_pkg::*;
#(
  parameter logic [47:0] src_mac       = 48'h00_37_FF_00_00_01,
  parameter logic [47:0] dst_mac       = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] ipv4_src      = {8'd192, 8'd168, 8'd0, 8'd2},
  parameter logic [31:0] ipv4_dst_base = {8'd192, 8'd168, 8'd0, 8'd1},
  parameter logic [15:0] src_port      = 16'd12345,
  parameter logic [15:0] dst_port      = 16'd12345,
  parameter logic [10:0] payload_words = 11'd640
) (
  input  logic        clk125,
  input  logic        sys_rst,
  input  logic        id,
  input  logic [28:0] fifo_dout,
  input  logic        fifo_empty,
  input  logic [10:0] fifo_cnt,
  output logic        fifo_rd_en,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        underrun
);

  localparam logic [15:0] TOT_LEN  = 16'(28 + 3 + 2 * int'(payload_words));
  localparam logic [15:0] UDP_LEN  = 16'(8 + 3 + 2 * int'(payload_words));
  localparam logic [10:0] PAY_END  = 11'(int'(OFS_PAY) + 2 * int'(payload_words) - 1);
  localparam logic [10:0] FCS_BEG  = PAY_END + 11'd1;
  localparam logic [10:0] FCS_END  = PAY_END + 11'd4;
  localparam logic [3:0]  IFG_LAST = 4'(IFG_LEN - 2);

  tx_state_e   state_q, state_d;
  logic [10:0] bcnt_q, bcnt_d;
  logic [3:0]  ifg_q, ifg_d;
  logic        x_q;
  logic [10:0] y_q;
  logic [15:0] csum_q;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        und_q, und_d;
  logic        crc_init, crc_en;
  logic [31:0] crc;
  logic        start;
  logic        pay_odd;
  logic [1:0]  fcs_idx;
  logic [31:0] dst_ip;
  logic [41:0][7:0] hdr;
  logic        unused;

  assign unused  = fifo_dout[28];
  assign start   = fifo_cnt >= payload_words;
  assign dst_ip  = {ipv4_dst_base[31:8], ipv4_dst_base[7:0] + {7'd0, id}};
  // OFS_PAY is odd, so odd payload bytes land on even bcnt.
  assign pay_odd = bcnt_q[0] ^ OFS_PAY[0];
  assign fcs_idx = 2'(bcnt_q - FCS_BEG);

  // Bytes 0x08..0x31 in wire order; hdr[41] goes out first.
  assign hdr = {dst_mac, src_mac, ETH_IPV4,
                IP_VER, 8'h00, TOT_LEN, 16'h0000, IP_FLAGS, IP_TTL, IP_UDP, csum_q,
                ipv4_src, dst_ip,
                src_port, dst_port, UDP_LEN, 16'h0000};

  always_ff @(posedge clk125) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)                        state_d = ST_PRE;
      ST_PRE:  if (bcnt_q == 11'd7)              state_d = ST_HDR;
      ST_HDR:  if (bcnt_q == OFS_INFO - 11'd1)   state_d = ST_INFO;
      ST_INFO: if (bcnt_q == OFS_PAY - 11'd1)    state_d = ST_PAY;
      ST_PAY:  if (bcnt_q == PAY_END)            state_d = ST_FCS;
      ST_FCS:  if (bcnt_q == FCS_END)            state_d = ST_IFG;
      ST_IFG:  if (ifg_q == IFG_LAST)            state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    txd_d      = 8'h00;
    tx_en_d    = 1'b0;
    und_d      = 1'b0;
    fifo_rd_en = 1'b0;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    case (state_q)
      ST_PRE: begin
        tx_en_d  = 1'b1;
        crc_init = 1'b1;
        txd_d    = (bcnt_q == 11'd7) ? 8'hD5 : 8'h55;
      end
      ST_HDR: begin
        tx_en_d = 1'b1;
        crc_en  = 1'b1;
        txd_d   = hdr[6'(11'd49 - bcnt_q)];
      end
      ST_INFO: begin
        tx_en_d = 1'b1;
        crc_en  = 1'b1;
        if (bcnt_q == OFS_INFO)              txd_d = PKT_VIDEO;
        else if (bcnt_q == OFS_INFO + 11'd1) txd_d = y_q[7:0];
        else                                 txd_d = {3'b000, x_q, 1'b0, y_q[10:8]};
      end
      ST_PAY: begin
        tx_en_d = 1'b1;
        crc_en  = 1'b1;
        // Starved bytes go out as zero so the frame length never changes.
        if (fifo_empty) und_d = 1'b1;
        else if (pay_odd) begin
          txd_d      = fifo_dout[7:0];
          fifo_rd_en = 1'b1;
        end else       txd_d = fifo_dout[15:8];
      end
      ST_FCS: begin
        tx_en_d = 1'b1;
        case (fcs_idx)
          2'd0:    txd_d = ~crc[7:0];
          2'd1:    txd_d = ~crc[15:8];
          2'd2:    txd_d = ~crc[23:16];
          default: txd_d = ~crc[31:24];
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    bcnt_d = bcnt_q + 11'd1;
    if (state_q == ST_IDLE || state_q == ST_IFG || state_d == ST_IFG) bcnt_d = '0;
    ifg_d = (state_q == ST_IFG) ? ifg_q + 4'd1 : 4'd0;
  end

  always_ff @(posedge clk125) begin
    if (sys_rst) begin
      bcnt_q  <= '0;
      ifg_q   <= '0;
      x_q     <= 1'b0;
      y_q     <= '0;
      csum_q  <= '0;
      txd_q   <= '0;
      tx_en_q <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      ifg_q   <= ifg_d;
      txd_q   <= txd_d;
      tx_en_q <= tx_en_d;
      und_q   <= und_d;
      if (state_q == ST_IDLE) csum_q <= ip_csum(TOT_LEN, ipv4_src, dst_ip);
      if (state_q == ST_IDLE && start) begin
        x_q <= fifo_dout[27];
        y_q <= fifo_dout[26:16];
      end
    end
  end

  crc32_d8 u_crc (
    .clk  (clk125),
    .rst  (sys_rst),
    .init (crc_init),
    .en   (crc_en),
    .d    (txd_d),
    .crc  (crc)
  );

  assign txd      = txd_q;
  assign tx_en    = tx_en_q;
  assign underrun = und_q;

endmodule

// File: tb/tb_fifo2gmii24.sv
// Random-payload bench: an FWFT FIFO model feeds the packetizer and each captured
// frame is compared with a byte-array frame built from the protocol rules.
module tb_fifo2gmii24;

  logic        clk125 = 1'b0;
  logic        sys_rst;
  logic        id;
  logic [28:0] fifo_dout;
  logic        fifo_empty;
  logic [10:0] fifo_cnt;
  logic        fifo_rd_en;
  logic [7:0]  txd;
  logic        tx_en;
  logic        underrun;

  fifo2gmii24 dut (
    .clk125     (clk125),
    .sys_rst    (sys_rst),
    .id         (id),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_cnt   (fifo_cnt),
    .fifo_rd_en (fifo_rd_en),
    .txd        (txd),
    .tx_en      (tx_en),
    .underrun   (underrun)
  );

  always #4 clk125 = ~clk125;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [28:0] q[$];
  logic [28:0] snap[$];
  bit   force_empty = 1'b0;
  int   force_lo = -1;
  bit   in_frame = 1'b0;
  bit   done = 1'b0;
  int   nb = 0, flen = 0, und_f = 0, pops_f = 0, rise_cyc = 0, last_hi = -100, gap = 0, hi_total = 0;
  logic [7:0] fb [0:2047];
  logic [7:0] eb [0:1336];
  int   exp_pops, exp_und;

  int   cidx [18] = '{'h00, 'h07, 'h14, 'h15, 'h16, 'h1F, 'h29, 'h2C, 'h2D,
                      'h18, 'h19, 'h2E, 'h2F, 'h32, 'h33, 'h34, 'h35, 'h36};
  logic [7:0] cval [18] = '{8'h55, 8'hD5, 8'h08, 8'h00, 8'h45, 8'h11, 8'h02, 8'h30, 8'h39,
                           8'h05, 8'h1F, 8'h05, 8'h0B, 8'h00, 8'hAB, 8'h10, 8'h12, 8'h34};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic void drive_fifo();
    fifo_dout  = (q.size() != 0) ? q[0] : 29'h0;
    fifo_cnt   = (q.size() > 2047) ? 11'd2047 : 11'(q.size());
    fifo_empty = force_empty || (q.size() == 0);
  endfunction

  // One clock: pop on the edge if the DUT asked for it, then observe the
  // registered outputs and set up the FIFO for the byte being computed next.
  task automatic step();
    logic rd_s;
    @(negedge clk125);
    rd_s = fifo_rd_en;
    @(posedge clk125);
    cyc++;
    if (rd_s && q.size() != 0) begin
      void'(q.pop_front());
      pops_f++;
    end
    #1;
    if (tx_en) begin
      hi_total++;
      if (!in_frame) begin
        in_frame = 1'b1;
        nb = 0; und_f = 0; pops_f = 0;
        gap = cyc - last_hi - 1;
        rise_cyc = cyc;
        snap = q;
      end
      if (nb < 2048) fb[nb] = txd;
      if (underrun) und_f++;
      nb++;
      last_hi = cyc;
    end else if (in_frame) begin
      in_frame = 1'b0;
      done = 1'b1;
      flen = nb;
    end
    force_empty = in_frame && force_lo >= 0 && (nb - 'h35) >= force_lo && (nb - 'h35) < force_lo + 4;
    drive_fifo();
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) q.push_back(29'($urandom));
    drive_fifo();
  endtask

  task automatic wait_done(input string tag, input int budget);
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) step();
    if (!done) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Expected frame from the protocol description, using the FIFO contents
  // seen at frame start and the payload indices where the FIFO was starved.
  task automatic build(input bit idb, input int flo);
    logic [7:0]  ih [20];
    logic [15:0] tl, ul, cs;
    logic [31:0] s, c;
    logic [47:0] sm;
    logic [10:0] y;
    logic        x;
    int k, hw;
    k = 0; hw = 0; exp_und = 0;
    sm = 48'h0037FF000001;
    tl = 16'(28 + 3 + 2 * 640);
    ul = 16'(8 + 3 + 2 * 640);
    x  = snap[0][27];
    y  = snap[0][26:16];
    for (int i = 0; i < 7; i++) eb[k++] = 8'h55;
    eb[k++] = 8'hD5;
    for (int i = 0; i < 6; i++) eb[k++] = 8'hFF;
    for (int i = 0; i < 6; i++) eb[k++] = sm[47 - 8*i -: 8];
    eb[k++] = 8'h08; eb[k++] = 8'h00;
    ih = '{8'h45, 8'h00, tl[15:8], tl[7:0], 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
           8'h00, 8'h00, 8'd192, 8'd168, 8'd0, 8'd2, 8'd192, 8'd168, 8'd0, 8'(1 + idb)};
    s = 0;
    for (int w = 0; w < 10; w++) s += {16'h0, ih[2*w], ih[2*w+1]};
    s = (s & 32'hFFFF) + (s >> 16);
    s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    ih[10] = cs[15:8]; ih[11] = cs[7:0];
    for (int i = 0; i < 20; i++) eb[k++] = ih[i];
    eb[k++] = 8'h30; eb[k++] = 8'h39; eb[k++] = 8'h30; eb[k++] = 8'h39;
    eb[k++] = ul[15:8]; eb[k++] = ul[7:0]; eb[k++] = 8'h00; eb[k++] = 8'h00;
    eb[k++] = 8'h00; eb[k++] = y[7:0]; eb[k++] = {3'b000, x, 1'b0, y[10:8]};
    for (int p = 0; p < 1280; p++) begin
      if ((flo >= 0 && p >= flo && p < flo + 4) || hw >= snap.size()) begin
        eb[k++] = 8'h00;
        exp_und++;
      end else if (p % 2 == 1) begin
        eb[k++] = snap[hw][7:0];
        hw++;
      end else eb[k++] = snap[hw][15:8];
    end
    c = 32'hFFFFFFFF;
    for (int i = 8; i < k; i++) begin
      c ^= {24'h0, eb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int j = 0; j < 4; j++) eb[k + j] = c[8*j +: 8];
    exp_pops = hw;
  endtask

  task automatic check_frame(input string nm, input bit idb, input int flo);
    int nmis, first;
    build(idb, flo);
    nmis = 0; first = -1;
    for (int i = 0; i < 1337; i++)
      if (fb[i] !== eb[i]) begin
        nmis++;
        if (first < 0) first = i;
      end
    chk({nm, "_len"}, flen, 1337);
    chk({nm, "_byte_mism"}, nmis, 0);
    if (nmis != 0) $display("  first differing byte 0x%0h", first);
    chk({nm, "_ipcsum"}, {fb['h20], fb['h21]}, {eb['h20], eb['h21]});
    chk({nm, "_fcs"}, {fb['h538], fb['h537], fb['h536], fb['h535]},
                      {eb['h538], eb['h537], eb['h536], eb['h535]});
    chk({nm, "_pops"}, pops_f, exp_pops);
    chk({nm, "_underruns"}, und_f, exp_und);
  endtask

  initial begin
    int c0;
    sys_rst = 1'b1; id = 1'b1;
    drive_fifo();
    repeat (3) step();
    sys_rst = 1'b0;
    step();
    chk("rst_tx_en", tx_en, 0);
    chk("rst_txd", txd, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_underrun", underrun, 0);

    // 639 words: never enough to start a frame.
    q.push_back({1'b0, 1'b1, 11'h0AB, 16'h1234});
    push_rand(638);
    hi_total = 0;
    repeat (2000) step();
    chk("idle639_tx_cycles", hi_total, 0);

    // Frame A: the 640th word arrives.
    push_rand(1);
    c0 = cyc;
    wait_done("A", 3000);
    chk("start_latency", rise_cyc - c0, 2);
    check_frame("A", 1'b1, -1);
    for (int i = 0; i < 18; i++) chk($sformatf("A_byte_%0h", cidx[i]), fb[cidx[i]], cval[i]);

    // Frames B and C back to back; C is starved for four payload bytes.
    push_rand(1290);
    wait_done("B", 3000);
    check_frame("B", 1'b1, -1);
    force_lo = 301;
    wait_done("C", 3000);
    check_frame("C", 1'b1, 301);
    chk("gap_BC", gap, 12);
    force_lo = -1;

    // Frame D aborted by reset at byte 600, then frame E runs cleanly.
    id = 1'b0;
    push_rand(640);
    for (int i = 0; i < 3000 && !(in_frame && nb == 601); i++) step();
    chk("D_reached_600", (in_frame && nb == 601), 1);
    sys_rst = 1'b1;
    step();
    chk("rst_mid_tx_en", tx_en, 0);
    chk("rst_mid_rd_en", fifo_rd_en, 0);
    sys_rst = 1'b0;
    repeat (20) step();
    push_rand(400);
    wait_done("E", 3000);
    check_frame("E", 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo2gmii24.md
# fifo2gmii24

Transmit-side packetizer for the HDMI-over-Ethernet video path. Drains 29-bit YUV pixel-pair words from a first-word-fall-through FIFO in the clk125 domain and emits complete GMII Ethernet/IPv4/UDP frames: preamble, headers, a 3-byte packet-info prefix, 1280 payload bytes and FCS. The output byte layout is exactly what gmii2fifo24 parses on the far end: eth_type at offset 0x14, info byte at 0x32, pixel data from 0x35. The block sits between the capture-side line FIFO and the GMII TX pins.

## Interface
- `src_mac`, 48'h00_37_FF_00_00_01: source MAC.
- `dst_mac`, 48'hFF_FF_FF_FF_FF_FF: destination MAC.
- `ipv4_src`, {192,168,0,2}: source IP.
- `ipv4_dst_base`, {192,168,0,1}: destination IP. The last octet has `id` added.
- `src_port`, 16'd12345: UDP source port.
- `dst_port`, 16'd12345: UDP destination port.
- `payload_words`, 11'd640: FIFO words per frame; each word is 2 payload bytes.

- `clk125`  in  1: 125 MHz GMII TX clock; the only clock.
- `sys_rst`  in  1: synchronous, active-high reset.
- `id`  in  1: stream id, added to the last destination IP octet.
- `fifo_dout`  in  29: FWFT head word. Bit 28 is reserved, bit 27 is x (half-line select), bits 26:16 are y, bits 15:8 are byte0, bits 7:0 are byte1.
- `fifo_empty`  in  1: FIFO empty.
- `fifo_cnt`  in  11: words currently stored.
- `fifo_rd_en`  out  1: pop strobe.
- `txd`  out  8: GMII TX data (registered).
- `tx_en`  out  1: GMII TX enable (registered).
- `underrun`  out  1: one-cycle pulse on a payload byte emitted while `fifo_empty`.

## Operation
- Reset values of all outputs are 0. The state is IDLE and the byte counter is 0.
- Byte counter `bcnt` is 11 bits and counts 0..1336 across the frame. A single FSM runs IDLE → PRE → HDR → INFO → PAY → FCS → IFG → IDLE.
- IDLE
  - Leave IDLE when `fifo_cnt >= payload_words`.
  - On leaving, latch x and y from `fifo_dout` without popping.
  - The IP header checksum is registered continuously while in IDLE.
- PRE, bytes 0–7: seven bytes of 0x55, then 0xD5.
- HDR, bytes 0x08–0x31, all fields big-endian (network order):
  - dst_mac, src_mac, then 0x0800.
  - IPv4 header: 0x45, 0x00, total_len = 28 + 3 + 2·payload_words (1311), id 0x0000, flags 0x4000, TTL 0x40, proto 0x11, checksum, src IP, dst IP.
  - UDP header: ports, udp_len = 8 + 3 + 2·payload_words (1291), checksum 0x0000.
- IP checksum: 16-bit one's-complement sum of the 10 header words with the checksum field 0. Fold carries twice, then invert.
- INFO, bytes 0x32–0x34:
  - 0x32: 0x00 (video).
  - 0x33: y[7:0].
  - 0x34: {3'b0, x, 1'b0, y[10:8]}.
- PAY, bytes 0x35–0x534:
  - Even payload byte: byte0 of the head word.
  - Odd payload byte: byte1 of the head word, with `fifo_rd_en` asserted in the same cycle.
  - If `fifo_empty` on a payload byte: emit 0x00, no pop, pulse `underrun`. Frame length is unchanged.
- FCS, bytes 0x535–0x538: CRC-32 over bytes 0x08–0x534.
  - Reflected 0x04C11DB7, init 0xFFFFFFFF, final complement.
  - Sent LSB byte first.
- IFG: `tx_en` = 0 for exactly 12 cycles, then IDLE. Back-to-back frames therefore have a 12-cycle gap minimum.
- `sys_rst` mid-frame: `tx_en` and `fifo_rd_en` drop on the next edge, the FSM returns to IDLE and `bcnt` returns to 0. The partial frame is not completed.

## Timing
- Start condition true in IDLE at edge N → `tx_en` = 1 with `txd` = 0x55 after edge N+1.
- `tx_en` stays high for exactly 8 + 1325 + 4 = 1337 consecutive cycles.
- `fifo_rd_en` is high for exactly `payload_words` cycles per frame (absent underrun), on alternate cycles.
- First pop happens on byte 0x36; last pop on byte 0x534.
- The CRC register updates on the same edge the byte is registered to `txd`. The FCS byte for 0x535 uses the complete CRC with no bubble.

## Structure
- Shared package `hdmits_pkg` holds:
  - offsets OFS_ETYPE = 0x14, OFS_INFO = 0x32, OFS_PAY = 0x35;
  - PKT_VIDEO = 8'h00 and PKT_AUDIO = 8'h01;
  - constants ETH_IPV4 = 16'h0800, IP_VER = 8'h45, IP_UDP = 8'h11.
- gmii2fifo24 shares this package.
- Sub-module `crc32_d8`: byte-wide Ethernet CRC. Inputs are clk, rst, init, en and d[7:0]; output crc[31:0], uninverted running value. Reused by a future RX FCS checker.

## Test plan
- Reset and idle:
  - After reset, `tx_en`, `txd`, `fifo_rd_en` and `underrun` are all 0.
  - With `fifo_cnt` = 639, no frame ever starts.
- Frame start: `fifo_cnt` 639 → 640 → `tx_en` rises the next cycle with 0x55×7, 0xD5. `tx_en` stays high for 1337 cycles.
- Header fields, with `id` = 1 and default parameters:
  - byte 0x14–0x15 = 08 00; byte 0x16 = 45; byte 0x1F = 11.
  - byte 0x29 = 0x02; bytes 0x2C–0x2D = 30 39.
  - bytes 0x18–0x19 = 05 1F; bytes 0x2E–0x2F = 05 0B.
  - The IP checksum equals the software model.
- Info and payload:
  - Head word {0, 1, 11'h0AB, 16'h1234} → bytes 0x32–0x34 = 00 AB 10, payload begins 12 34.
  - 640 pops total.
  - A loopback into gmii2fifo24 with `id` = 1 yields datain y = 0x0AB, x = 1.
- FCS and back-to-back:
  - FCS equals the software CRC-32 of bytes 0x08–0x534.
  - With `fifo_cnt` held ≥ 1280, the second frame starts exactly 12 idle cycles after the first ends.
- Faults:
  - `fifo_empty` forced for 4 cycles mid-payload → four 0x00 bytes and four `underrun` pulses; frame length stays 1337.
  - `sys_rst` at byte 600 → `tx_en` is 0 the next cycle and a new frame starts cleanly afterwards.
